// File: rtl/imem_stream_loader_if.sv
// Byte-stream RX handshake and instruction-RAM programming bus for imem_stream_loader.
// master = byte source / RAM side, slave = the loader.
interface imem_stream_loader_if #(
  parameter int ADDR_W = 3
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              prog_mode;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              prog_write;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_written;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, prog_mode, prog_addr, prog_data, prog_write,
           cpu_hold, load_done, load_error, words_written
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, prog_mode, prog_addr, prog_data, prog_write,
           cpu_hold, load_done, load_error, words_written
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Frames SYNC, count N, 4*N little-endian data bytes into instruction-RAM writes, holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_stream_loader #(
  parameter int         DEPTH          = 8,
  parameter int         ADDR_W         = 3,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 reset,
  imem_stream_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CSUM
  } state_t;

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              prog_mode_q, prog_mode_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [31:0]       prog_data_q, prog_data_d;
  logic              prog_write_q, prog_write_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic [ADDR_W:0]   words_written_q, words_written_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       tmo_q, tmo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic rx_fire;
  logic tmo_hit;
  logic go_error;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  // Idle-cycle count only; any accepted byte restarts the window.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && !rx_fire && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d         = state_q;
    prog_mode_d     = prog_mode_q;
    prog_addr_d     = prog_addr_q;
    prog_data_d     = prog_data_q;
    prog_write_d    = 1'b0;
    cpu_hold_d      = cpu_hold_q;
    load_done_d     = 1'b0;
    load_error_d    = load_error_q;
    words_written_d = words_written_q;
    byte_idx_d      = byte_idx_q;
    word_idx_d      = word_idx_q;
    last_idx_d      = last_idx_q;
    word_d          = word_q;
    go_error        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d          = csum_q;
`endif

    tmo_d = '0;
    if ((state_q == S_COUNT || state_q == S_DATA || state_q == S_CSUM) && !rx_fire)
      tmo_d = tmo_q + 16'd1;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (rx_fire && bus.rx_data == SYNC_BYTE) begin
          state_d         = S_COUNT;
          prog_mode_d     = 1'b1;
          cpu_hold_d      = 1'b1;
          load_error_d    = 1'b0;
          words_written_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d          = '0;
`endif
        end
      end
      S_COUNT: begin
        if (rx_fire) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > 8'(DEPTH)) begin
            go_error = 1'b1;
          end else begin
            last_idx_d = ADDR_W'(bus.rx_data - 8'd1);
            byte_idx_d = '0;
            word_idx_d = '0;
            state_d    = S_DATA;
          end
        end else if (tmo_hit) begin
          go_error = 1'b1;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            state_d         = S_WRITE;
            prog_write_d    = 1'b1;
            prog_addr_d     = word_idx_q;
            prog_data_d     = word_d;
            words_written_d = words_written_q + (ADDR_W+1)'(1);
          end
        end else if (tmo_hit) begin
          go_error = 1'b1;
        end
      end
      S_WRITE: begin
        if (word_idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d     = S_CSUM;
`else
          state_d     = S_DONE;
          load_done_d = 1'b1;
`endif
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = S_DATA;
        end
      end
      S_DONE: begin
        prog_mode_d = 1'b0;
        cpu_hold_d  = 1'b0;
        state_d     = S_IDLE;
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_fire) begin
          if (bus.rx_data == csum_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
          end else begin
            go_error = 1'b1;
          end
        end else if (tmo_hit) begin
          go_error = 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Core stays held after a failed load; software must reload before release.
    if (go_error) begin
      state_d      = S_ERROR;
      load_error_d = 1'b1;
      prog_mode_d  = 1'b0;
    end

    rx_ready_d = !(state_d == S_WRITE || state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rx_ready_q      <= 1'b1;
      prog_mode_q     <= 1'b0;
      prog_addr_q     <= '0;
      prog_data_q     <= '0;
      prog_write_q    <= 1'b0;
      cpu_hold_q      <= 1'b0;
      load_done_q     <= 1'b0;
      load_error_q    <= 1'b0;
      words_written_q <= '0;
      byte_idx_q      <= '0;
      word_idx_q      <= '0;
      last_idx_q      <= '0;
      word_q          <= '0;
      tmo_q           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rx_ready_q      <= rx_ready_d;
      prog_mode_q     <= prog_mode_d;
      prog_addr_q     <= prog_addr_d;
      prog_data_q     <= prog_data_d;
      prog_write_q    <= prog_write_d;
      cpu_hold_q      <= cpu_hold_d;
      load_done_q     <= load_done_d;
      load_error_q    <= load_error_d;
      words_written_q <= words_written_d;
      byte_idx_q      <= byte_idx_d;
      word_idx_q      <= word_idx_d;
      last_idx_q      <= last_idx_d;
      word_q          <= word_d;
      tmo_q           <= tmo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q          <= csum_d;
`endif
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.prog_mode     = prog_mode_q;
  assign bus.prog_addr     = prog_addr_q;
  assign bus.prog_data     = prog_data_q;
  assign bus.prog_write    = prog_write_q;
  assign bus.cpu_hold      = cpu_hold_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_error    = load_error_q;
  assign bus.words_written = words_written_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized frame-level bench for imem_stream_loader with a queue of expected RAM writes.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_stream_loader;
  localparam int         DEPTH  = 8;
  localparam int         ADDR_W = 3;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         TMO    = 1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) intf();

  imem_stream_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(intf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  cmp_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   gap_max  = 3;
  logic prev_write = 1'b0;
  logic prev_done  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write must be the next expected one, inside a session, single-cycle, with rx stalled.
  always @(negedge clk) begin
    if (!reset) begin
      if (intf.prog_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %08h, expected no write",
                   intf.prog_addr, intf.prog_data);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("write_addr", 32'(intf.prog_addr), 32'(cmp_e.addr));
          chk("write_data", intf.prog_data, cmp_e.data);
        end
        chk("write_in_session", 32'(intf.prog_mode), 32'd1);
        chk("write_one_cycle", 32'(prev_write), 32'd0);
        chk("ready_low_on_write", 32'(intf.rx_ready), 32'd0);
      end
      if (!intf.rx_ready)
        chk("ready_low_only_write_done", 32'(intf.prog_write | intf.load_done), 32'd1);
      if (intf.load_done) begin
        done_cnt++;
        chk("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_write = intf.prog_write;
      prev_done  = intf.load_done;
    end else begin
      prev_write = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    intf.rx_data  = b;
    intf.rx_valid = 1'b1;
    while (!intf.rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!intf.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_stuck: got rx_ready 0 for %0d cycles, expected 1", guard);
    end
    @(negedge clk);
    intf.rx_valid = 1'b0;
    intf.rx_data  = 8'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"},      32'(intf.rx_ready), 32'd1);
    chk({tag, "_prog_mode"},     32'(intf.prog_mode), 32'd0);
    chk({tag, "_prog_addr"},     32'(intf.prog_addr), 32'd0);
    chk({tag, "_prog_data"},     intf.prog_data, 32'd0);
    chk({tag, "_prog_write"},    32'(intf.prog_write), 32'd0);
    chk({tag, "_cpu_hold"},      32'(intf.cpu_hold), 32'd0);
    chk({tag, "_load_done"},     32'(intf.load_done), 32'd0);
    chk({tag, "_load_error"},    32'(intf.load_error), 32'd0);
    chk({tag, "_words_written"}, 32'(intf.words_written), 32'd0);
  endtask

  // Count byte onward; the session has already been opened by a SYNC byte.
  task automatic frame_body(input logic [7:0] n, input bit bad_cs);
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         e;
    int          d0;
    bit          ok_n;
    bit          exp_err;
    cs   = 8'h00;
    d0   = done_cnt;
    ok_n = (n >= 8'd1 && n <= 8'(DEPTH));
    send_byte(n);
    if (ok_n) begin
      for (int i = 0; i < int'(n); i++) begin
        w      = $urandom;
        e.addr = ADDR_W'(i);
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
          cs = cs ^ w[8*k +: 8];
          send_byte(w[8*k +: 8]);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = !ok_n || bad_cs;
    if (ok_n) send_byte(bad_cs ? ~cs : cs);
`else
    exp_err = !ok_n || (bad_cs && 1'b0);
`endif
    idle(3);
    chk("frame_done_count",    32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
    chk("frame_load_error",    32'(intf.load_error), 32'(exp_err));
    chk("frame_cpu_hold",      32'(intf.cpu_hold), 32'(exp_err));
    chk("frame_prog_mode",     32'(intf.prog_mode), 32'd0);
    chk("frame_words_written", 32'(intf.words_written), ok_n ? 32'(n) : 32'd0);
    chk("frame_writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] n, input bit bad_cs);
    send_byte(SYNC);
    chk("sync_prog_mode",  32'(intf.prog_mode), 32'd1);
    chk("sync_cpu_hold",   32'(intf.cpu_hold), 32'd1);
    chk("sync_error_clr",  32'(intf.load_error), 32'd0);
    chk("sync_words_zero", 32'(intf.words_written), 32'd0);
    frame_body(n, bad_cs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t e;
    int  d0;
    int  cnt;
    intf.rx_valid = 1'b0;
    intf.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("reset");

    // Smallest load: one word 0x00000013.
    d0 = done_cnt;
    send_byte(SYNC);
    send_byte(8'h01);
    e.addr = '0;
    e.data = 32'h0000_0013;
    exp_q.push_back(e);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t1_write_latency", 32'(intf.prog_write), 32'd1);
    chk("t1_prog_data", intf.prog_data, 32'h0000_0013);
    chk("t1_cpu_hold_during", 32'(intf.cpu_hold), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h13);
`endif
    idle(3);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_cpu_hold_after", 32'(intf.cpu_hold), 32'd0);
    chk("t1_words_written", 32'(intf.words_written), 32'd1);

    // Full-depth load, then illegal counts, then recovery.
    run_frame(8'd8, 1'b0);
    run_frame(8'd0, 1'b0);
    run_frame(8'd9, 1'b0);
    run_frame(8'd1, 1'b0);

    // Timeout after one full word and one stray byte.
    send_byte(SYNC);
    send_byte(8'h02);
    e.addr = '0;
    e.data = 32'hDEAD_BEEF;
    exp_q.push_back(e);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_byte(8'h55);
    cnt = 0;
    while (!intf.load_error && cnt < TMO + 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_window", 32'(cnt >= TMO - 1 && cnt <= TMO + 1), 32'd1);
    chk("tmo_cpu_hold", 32'(intf.cpu_hold), 32'd1);
    chk("tmo_prog_mode", 32'(intf.prog_mode), 32'd0);
    chk("tmo_words_written", 32'(intf.words_written), 32'd1);
    chk("tmo_writes_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a word discards it.
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midreset");
    send_byte(8'h00);
    chk("drop_prog_mode", 32'(intf.prog_mode), 32'd0);
    run_frame(8'd2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    d0 = done_cnt;
    send_byte(SYNC);
    send_byte(8'h01);
    e.addr = '0;
    e.data = 32'h0000_0013;
    exp_q.push_back(e);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(3);
    chk("cs_bad_error", 32'(intf.load_error), 32'd1);
    chk("cs_bad_no_done", 32'(done_cnt - d0), 32'd0);
    send_byte(SYNC);
    send_byte(8'h01);
    exp_q.push_back(e);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h13);
    idle(3);
    chk("cs_good_done", 32'(done_cnt - d0), 32'd1);
    chk("cs_good_error", 32'(intf.load_error), 32'd0);
`endif

    // Random frames with dropped noise bytes, random gaps and occasional bad count/checksum.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] noise;
      logic [7:0] n;
      gap_max = (it % 2 == 0) ? 0 : 3;
      if ($urandom_range(0, 2) == 0) begin
        noise = 8'($urandom);
        if (noise == SYNC) noise = 8'h5A;
        send_byte(noise);
      end
      if ($urandom_range(0, 9) == 0)
        n = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
      else
        n = 8'($urandom_range(1, DEPTH));
      run_frame(n, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
